// File: rtl/reg_issue_wb.sv
// Issue/writeback stage around the ALU result-select decoder: accepts instruction
// words, drives operands to the decoder and writes its results into a 4-entry register file.
module reg_issue_wb #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [WIDTH-1:0]  RA,
  output logic [WIDTH-1:0]  RB,
  output logic [2:0]        sel,
  output logic [2:0]        ZNC_in,
  input  logic [WIDTH-1:0]  alu_a,
  input  logic [WIDTH-1:0]  alu_b,
  input  logic [2:0]        alu_znc,
  output logic              done,
  input  logic [REG_AW-1:0] rd_idx,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << REG_AW;

  typedef enum logic [1:0] {IDLE, LDW, ISSUE, WB} state_t;

  // state is the observable FSM state for assertions bound to this module.
  state_t state, state_nxt;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [2:0]        flags;
  logic [REG_AW-1:0] a_q, b_q;
  logic [7:0]        imm_q;
  logic              accept;

  // Handshake: a word transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr is don't-care whenever instr_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = rst_n;
        if (instr_valid && rst_n) begin
          accept    = 1'b1;
          state_nxt = instr[8] ? LDW : ISSUE;
        end
      end
      LDW: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ISSUE: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured on the accept edge, so RA/RB/sel are stable for
  // the whole ISSUE+WB window while the decoder settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      flags <= '0;
      RA    <= '0;
      RB    <= '0;
      sel   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= REG_AW'(instr[12:11]);
        b_q   <= REG_AW'(instr[10:9]);
        imm_q <= instr[7:0];
        if (!instr[8]) begin
          RA  <= regs[REG_AW'(instr[12:11])];
          RB  <= regs[REG_AW'(instr[10:9])];
          sel <= instr[15:13];
        end
      end
      if (state == LDW) regs[a_q] <= WIDTH'(imm_q);
      // The a write follows the b write so index a wins when a == b.
      if (state == WB) begin
        regs[b_q] <= alu_b;
        regs[a_q] <= alu_a;
        flags     <= alu_znc;
      end
    end
  end

  assign ZNC_in  = flags;
  assign rd_data = regs[rd_idx];

endmodule

// File: tb/tb_reg_issue_wb.sv
// Self-checking bench for reg_issue_wb: directed vector table, multi-cycle corner
// sequences, then random instructions against a register-file reference model.
`timescale 1ns/1ps
module tb_reg_issue_wb;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [15:0]  instr;
  logic [W-1:0] RA, RB;
  logic [2:0]   sel, ZNC_in, alu_znc;
  logic [W-1:0] alu_a, alu_b;
  logic         done;
  logic [1:0]   rd_idx;
  logic [W-1:0] rd_data;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   f;
  } alu_t;

  typedef struct {
    logic [15:0]  w;
    logic [W-1:0] r [4];
    logic [2:0]   f;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference state: register contents, flags, and the operand outputs the stage should hold.
  logic [W-1:0] m_regs [4];
  logic [2:0]   m_flags;
  logic [W-1:0] m_ra, m_rb;
  logic [2:0]   m_sel;

  reg_issue_wb #(.WIDTH(W), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .RA(RA), .RB(RB), .sel(sel), .ZNC_in(ZNC_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_znc(alu_znc), .done(done),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #10 clk = ~clk;

  // Stand-in for the result-select decoder.
  function automatic alu_t alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input logic [2:0] zin);
    alu_t r;
    logic [W:0] w;
    logic c, keep;
    r.a = '0; r.b = b; c = zin[0]; keep = 1'b0; w = '0;
    case (op)
      3'b100: begin w = {1'b0, a} + {1'b0, b}; r.a = w[W-1:0]; c = w[W]; end
      3'b101: begin w = {1'b0, a} - {1'b0, b}; r.a = w[W-1:0]; c = w[W]; end
      3'b110: r.a = a | b;
      3'b111: r.a = a & b;
      3'b000: r.a = a ^ b;
      3'b001: begin r.a = a >> 1; c = a[0]; end
      3'b010: r.a = b;
      default: begin r.a = b; r.b = a; keep = 1'b1; end
    endcase
    r.f = keep ? zin : {r.a == '0, r.a[W-1], c};
    return r;
  endfunction

  alu_t alu_now;
  assign alu_now = alu_ref(RA, RB, sel, ZNC_in);
  assign alu_a   = alu_now.a;
  assign alu_b   = alu_now.b;
  assign alu_znc = alu_now.f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = '0; m_ra = '0; m_rb = '0; m_sel = '0;
  endtask

  // Architectural effect of one instruction, straight from the instruction format.
  task automatic model_exec(input logic [15:0] w);
    int a, b;
    alu_t r;
    a = int'(w[12:11]);
    b = int'(w[10:9]);
    if (w[8]) begin
      m_regs[a] = {8'h00, w[7:0]};
    end else begin
      m_ra = m_regs[a]; m_rb = m_regs[b]; m_sel = w[15:13];
      r = alu_ref(m_regs[a], m_regs[b], w[15:13], m_flags);
      m_regs[b] = r.b;
      m_regs[a] = r.a;
      m_flags   = r.f;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), 32'(rd_data), 32'(m_regs[i]));
    end
    check({tag, " flags"}, 32'(ZNC_in), 32'(m_flags));
  endtask

  task automatic check_ops(input string tag);
    check({tag, " RA"}, 32'(RA), 32'(m_ra));
    check({tag, " RB"}, 32'(RB), 32'(m_rb));
    check({tag, " sel"}, 32'(sel), 32'(m_sel));
  endtask

  // Driver: called on a negedge while idle; returns on the negedge after retirement.
  task automatic run_instr(input logic [15:0] w, input string tag);
    instr = w; instr_valid = 1'b1;
    check({tag, " ready idle"}, 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    check({tag, " ready busy"}, 32'(instr_ready), 32'd0);
    if (w[8]) begin
      check({tag, " done ldw"}, 32'(done), 32'd1);
      check_ops({tag, " ldw"});
      model_exec(w);
    end else begin
      model_exec(w);
      check({tag, " done issue"}, 32'(done), 32'd0);
      check_ops({tag, " issue"});
      @(negedge clk);
      check({tag, " ready wb"}, 32'(instr_ready), 32'd0);
      check({tag, " done wb"}, 32'(done), 32'd1);
      check_ops({tag, " wb"});
    end
    @(negedge clk);
    check({tag, " done idle"}, 32'(done), 32'd0);
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst done", 32'(done), 32'd0);
    check_ops("rst");
    check_regs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst ready after release", 32'(instr_ready), 32'd1);
  endtask

  vec_t vecs [15];
  int acc, dones;
  int acc_at [4];

  task automatic set_vec(input int i, input logic [15:0] w, input logic [W-1:0] r0,
                         input logic [W-1:0] r1, input logic [W-1:0] r2,
                         input logic [W-1:0] r3, input logic [2:0] f);
    vecs[i].w = w;
    vecs[i].r[0] = r0; vecs[i].r[1] = r1; vecs[i].r[2] = r2; vecs[i].r[3] = r3;
    vecs[i].f = f;
  endtask

  initial begin
    instr = '0; instr_valid = 1'b0; rd_idx = '0; rst_n = 1'b0;

    // Hand-derived expectations for a directed program.
    set_vec(0,  16'h0105, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 3'b000);
    set_vec(1,  16'h0903, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 3'b000);
    set_vec(2,  16'h6200, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 3'b000);
    set_vec(3,  16'h6200, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 3'b000);
    set_vec(4,  16'h8200, 16'h0008, 16'h0003, 16'h0000, 16'h0000, 3'b000);
    set_vec(5,  16'hAA00, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 3'b100);
    set_vec(6,  16'h11FF, 16'h0008, 16'h0000, 16'h00FF, 16'h0000, 3'b100);
    set_vec(7,  16'h1980, 16'h0008, 16'h0000, 16'h00FF, 16'h0080, 3'b100);
    set_vec(8,  16'hD600, 16'h0008, 16'h0000, 16'h00FF, 16'h0080, 3'b000);
    set_vec(9,  16'h3000, 16'h0008, 16'h0000, 16'h007F, 16'h0080, 3'b001);
    set_vec(10, 16'h1E00, 16'h0008, 16'h0000, 16'h007F, 16'h0000, 3'b101);
    set_vec(11, 16'h4C00, 16'h0008, 16'h007F, 16'h007F, 16'h0000, 3'b001);
    set_vec(12, 16'hE200, 16'h0008, 16'h007F, 16'h007F, 16'h0000, 3'b001);
    set_vec(13, 16'hBA00, 16'h0008, 16'h007F, 16'h007F, 16'hFF81, 3'b011);
    set_vec(14, 16'hF1AB, 16'h0008, 16'h007F, 16'h00AB, 16'hFF81, 3'b011);

    @(negedge clk);
    do_reset();

    for (int v = 0; v < 15; v++) begin
      run_instr(vecs[v].w, $sformatf("vec%0d", v));
      for (int i = 0; i < 4; i++) begin
        rd_idx = 2'(i);
        #1;
        check($sformatf("vec%0d table reg%0d", v, i), 32'(rd_data), 32'(vecs[v].r[i]));
      end
      check($sformatf("vec%0d table flags", v), 32'(ZNC_in), 32'(vecs[v].f));
    end

    // Back-to-back: instr_valid held high across three ADD R0,R1.
    do_reset();
    run_instr(16'h0105, "b2b ld0");
    run_instr(16'h0903, "b2b ld1");
    instr = 16'h8200; instr_valid = 1'b1; acc = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      if (instr_ready && instr_valid) begin
        acc_at[acc] = c;
        acc++;
        model_exec(16'h8200);
      end
      @(posedge clk);
      #1;
      if (acc == 3) instr_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b accepts", 32'(acc), 32'd3);
    check("b2b gap1", 32'(acc_at[1] - acc_at[0]), 32'd3);
    check("b2b gap2", 32'(acc_at[2] - acc_at[1]), 32'd3);
    check("b2b dones", 32'(dones), 32'd3);
    rd_idx = 2'd0;
    #1;
    check("b2b R0 final", 32'(rd_data), 32'h000E);
    check_regs("b2b");

    // Reset pulsed during WB of ADD R0,R1 aborts the writeback.
    do_reset();
    run_instr(16'h0105, "abort ld0");
    run_instr(16'h0903, "abort ld1");
    instr = 16'h8200; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort in wb", 32'(done), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort done", 32'(done), 32'd0);
    check("abort ready during reset", 32'(instr_ready), 32'd0);
    check_ops("abort");
    check_regs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort ready after release", 32'(instr_ready), 32'd1);
    check("abort done after release", 32'(done), 32'd0);
    check_regs("abort post");

    // Random instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      run_instr(16'($urandom_range(0, 16'hFFFF)), $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
